// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the MEM stage and MEM/WB register.
// The write-back and hazard units reuse the MEM/WB bundle widths.
package mem_access_stage_pkg;

    localparam int MA_DATA_W = 16;
    localparam int MA_REG_AW = 3;

    localparam int WB_DATA_W = MA_DATA_W;
    localparam int WB_RD_W   = MA_REG_AW;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_DATA_W-1:0] read_data_mem;
        logic [WB_DATA_W-1:0] alu_result;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic [WB_RD_W-1:0]   rd;
    } mem_wb_t;

endpackage

// File: rtl/mem_access_stage_mem_wb_latch.sv
// MEM/WB pipeline register; data fields hold across bubbles,
// RegWrite is always qualified by the slot valid bit.
module mem_wb_latch #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_read_data,
    input  logic [DATA_W-1:0] d_alu_result,
    input  logic              d_mem_to_reg,
    input  logic              d_reg_write,
    input  logic [REG_AW-1:0] d_rd,
    output logic              wb_valid,
    output logic [DATA_W-1:0] read_data_mem,
    output logic [DATA_W-1:0] alu_result,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic [REG_AW-1:0] wb_rd
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            read_data_mem <= '0;
            alu_result    <= '0;
            MemToReg      <= 1'b0;
            RegWrite      <= 1'b0;
            wb_rd         <= '0;
        end else begin
            wb_valid <= d_valid;
            RegWrite <= d_valid & d_reg_write;
            if (d_valid) begin
                read_data_mem <= d_read_data;
                alu_result    <= d_alu_result;
                MemToReg      <= d_mem_to_reg;
                wb_rd         <= d_rd;
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access with timeout abort,
// upstream stall while outstanding, feeding the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = MA_DATA_W,
    parameter int REG_AW  = MA_REG_AW,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemToReg,
    input  logic              ex_RegWrite,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [DATA_W-1:0] read_data_mem,
    output logic [DATA_W-1:0] alu_result,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap_addr, cap_wdata;
    logic              cap_we, cap_load, cap_m2r, cap_rw;
    logic [REG_AW-1:0] cap_rd;
    logic              ex_mem_op, timeout;

    logic              d_valid, d_m2r, d_rw;
    logic [DATA_W-1:0] d_rdata, d_alu;
    logic [REG_AW-1:0] d_rd;

    assign ex_mem_op = ex_valid & (ex_MemRead | ex_MemWrite);

    always_comb begin
        state_n   = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        timeout   = 1'b0;
        d_valid   = 1'b0;
        d_rdata   = '0;
        d_alu     = '0;
        d_m2r     = 1'b0;
        d_rw      = 1'b0;
        d_rd      = '0;
        unique case (state)
            IDLE: begin
                if (ex_mem_op) begin
                    mem_req   = 1'b1;
                    stall     = 1'b1;
                    mem_we    = ex_MemWrite;
                    mem_addr  = ex_alu_result;
                    mem_wdata = ex_write_data;
                    state_n   = WAIT;
                end else if (ex_valid) begin
                    d_valid = 1'b1;
                    d_alu   = ex_alu_result;
                    d_m2r   = ex_MemToReg;
                    d_rw    = ex_RegWrite;
                    d_rd    = ex_rd;
                end
            end
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = cap_we;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                d_alu     = cap_addr;
                d_m2r     = cap_m2r;
                d_rd      = cap_rd;
                if (mem_ack) begin
                    d_valid = 1'b1;
                    d_rdata = cap_load ? mem_rdata : '0;
                    d_rw    = cap_rw;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Abort retires the instruction without a register write
                    timeout = 1'b1;
                    d_valid = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_err   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            cap_load  <= 1'b0;
            cap_m2r   <= 1'b0;
            cap_rw    <= 1'b0;
            cap_rd    <= '0;
        end else begin
            state <= state_n;
            if (state == WAIT && state_n == WAIT)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            if (timeout)
                mem_err <= 1'b1;
            if (state == IDLE && ex_mem_op) begin
                cap_addr  <= ex_alu_result;
                cap_wdata <= ex_write_data;
                cap_we    <= ex_MemWrite;
                cap_load  <= ex_MemRead & ~ex_MemWrite;
                cap_m2r   <= ex_MemToReg;
                cap_rw    <= ex_RegWrite;
                cap_rd    <= ex_rd;
            end
        end
    end

    mem_wb_latch #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_mem_wb (
        .clk           (clk),
        .rst           (rst),
        .d_valid       (d_valid),
        .d_read_data   (d_rdata),
        .d_alu_result  (d_alu),
        .d_mem_to_reg  (d_m2r),
        .d_reg_write   (d_rw),
        .d_rd          (d_rd),
        .wb_valid      (wb_valid),
        .read_data_mem (read_data_mem),
        .alu_result    (alu_result),
        .MemToReg      (MemToReg),
        .RegWrite      (RegWrite),
        .wb_rd         (wb_rd)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle vector table plus
// hand-written timeout and reset-mid-access sequences.
module tb_mem_access_stage;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_result, ex_write_data;
    logic        ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegWrite;
    logic [2:0]  ex_rd;
    logic        stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [15:0] read_data_mem, alu_result;
    logic        MemToReg, RegWrite;
    logic [2:0]  wb_rd;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_write_data (ex_write_data),
        .ex_MemRead    (ex_MemRead),
        .ex_MemWrite   (ex_MemWrite),
        .ex_MemToReg   (ex_MemToReg),
        .ex_RegWrite   (ex_RegWrite),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .wb_valid      (wb_valid),
        .read_data_mem (read_data_mem),
        .alu_result    (alu_result),
        .MemToReg      (MemToReg),
        .RegWrite      (RegWrite),
        .wb_rd         (wb_rd),
        .mem_err       (mem_err)
    );

    typedef struct {
        logic        v;
        logic [15:0] alu, wd;
        logic        mr, mw, m2r, rw;
        logic [2:0]  rd;
        logic        ack;
        logic [15:0] rdata;
        logic        stall, req, we;
        logic [15:0] addr, ewd;
        logic        wbv;
        logic [15:0] rdm, walu;
        logic        wm2r, wrw;
        logic [2:0]  wrd;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] alu,
                         input logic [15:0] wd, input logic mr,
                         input logic mw, input logic m2r, input logic rw,
                         input logic [2:0] rd, input logic ack,
                         input logic [15:0] rdata);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_write_data = wd;
        ex_MemRead    = mr;
        ex_MemWrite   = mw;
        ex_MemToReg   = m2r;
        ex_RegWrite   = rw;
        ex_rd         = rd;
        mem_ack       = ack;
        mem_rdata     = rdata;
    endtask

    task automatic chk_wb(input string p, input logic v,
                          input logic [15:0] rdm, input logic [15:0] alu,
                          input logic m2r, input logic rw,
                          input logic [2:0] rd);
        chk({p, "_wb_valid"}, {15'd0, wb_valid}, {15'd0, v});
        chk({p, "_rdata"}, read_data_mem, rdm);
        chk({p, "_alu"}, alu_result, alu);
        chk({p, "_m2r"}, {15'd0, MemToReg}, {15'd0, m2r});
        chk({p, "_regwr"}, {15'd0, RegWrite}, {15'd0, rw});
        chk({p, "_rd"}, {13'd0, wb_rd}, {13'd0, rd});
    endtask

    initial begin
        vt[0]  = '{H,16'h1234,16'h0,L,L,L,H,3'd3,L,16'h0,
                   L,L,L,16'h0,16'h0, H,16'h0,16'h1234,L,H,3'd3};
        vt[1]  = '{L,16'h0,16'h0,L,L,L,L,3'd0,L,16'h0,
                   L,L,L,16'h0,16'h0, L,16'h0,16'h1234,L,L,3'd3};
        vt[2]  = '{H,16'h0040,16'h0,H,L,H,H,3'd5,L,16'h0,
                   H,H,L,16'h0040,16'h0, L,16'h0,16'h1234,L,L,3'd3};
        vt[3]  = vt[2];
        vt[4]  = vt[2];
        vt[5]  = '{H,16'h0040,16'h0,H,L,H,H,3'd5,H,16'hBEEF,
                   L,H,L,16'h0040,16'h0, H,16'hBEEF,16'h0040,H,H,3'd5};
        vt[6]  = '{L,16'h0,16'h0,L,L,L,L,3'd0,L,16'h0,
                   L,L,L,16'h0,16'h0, L,16'hBEEF,16'h0040,H,L,3'd5};
        vt[7]  = '{H,16'h0010,16'hA5A5,L,H,L,L,3'd0,L,16'h0,
                   H,H,H,16'h0010,16'hA5A5, L,16'hBEEF,16'h0040,H,L,3'd5};
        vt[8]  = '{H,16'h0010,16'hA5A5,L,H,L,L,3'd0,H,16'hFFFF,
                   L,H,H,16'h0010,16'hA5A5, H,16'h0,16'h0010,L,L,3'd0};
        vt[9]  = '{H,16'h0010,16'h0,H,L,H,H,3'd2,L,16'h0,
                   H,H,L,16'h0010,16'h0, L,16'h0,16'h0010,L,L,3'd0};
        vt[10] = '{H,16'h0010,16'h0,H,L,H,H,3'd2,H,16'hA5A5,
                   L,H,L,16'h0010,16'h0, H,16'hA5A5,16'h0010,H,H,3'd2};
        vt[11] = '{L,16'h0,16'h0,L,L,L,L,3'd0,H,16'h1111,
                   L,L,L,16'h0,16'h0, L,16'hA5A5,16'h0010,H,L,3'd2};
        vt[12] = '{L,16'h0,16'h0,L,L,L,L,3'd0,L,16'h0,
                   L,L,L,16'h0,16'h0, L,16'hA5A5,16'h0010,H,L,3'd2};
        vt[13] = '{H,16'h0022,16'h0F0F,H,H,H,L,3'd1,L,16'h0,
                   H,H,H,16'h0022,16'h0F0F, L,16'hA5A5,16'h0010,H,L,3'd2};
        vt[14] = '{H,16'h0022,16'h0F0F,H,H,H,L,3'd1,H,16'h7777,
                   L,H,H,16'h0022,16'h0F0F, H,16'h0,16'h0022,H,L,3'd1};
        vt[15] = '{H,16'h0030,16'h0,H,L,H,H,3'd4,H,16'hDEAD,
                   H,H,L,16'h0030,16'h0, L,16'h0,16'h0022,H,L,3'd1};
        vt[16] = '{H,16'h0030,16'h0,H,L,H,H,3'd4,H,16'hCAFE,
                   L,H,L,16'h0030,16'h0, H,16'hCAFE,16'h0030,H,H,3'd4};
        vt[17] = '{L,16'h0,16'h0,L,L,L,L,3'd0,L,16'h0,
                   L,L,L,16'h0,16'h0, L,16'hCAFE,16'h0030,H,L,3'd4};

        rst = 1'b1;
        drive(L, 16'h0, 16'h0, L, L, L, L, 3'd0, L, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_wb("reset", L, 16'h0, 16'h0, L, L, 3'd0);
        chk("reset_req", {15'd0, mem_req}, 16'h0);
        chk("reset_err", {15'd0, mem_err}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vt[i].v, vt[i].alu, vt[i].wd, vt[i].mr, vt[i].mw,
                  vt[i].m2r, vt[i].rw, vt[i].rd, vt[i].ack, vt[i].rdata);
            #1;
            chk($sformatf("r%0d_stall", i), {15'd0, stall},
                {15'd0, vt[i].stall});
            chk($sformatf("r%0d_req", i), {15'd0, mem_req},
                {15'd0, vt[i].req});
            chk($sformatf("r%0d_we", i), {15'd0, mem_we},
                {15'd0, vt[i].we});
            chk($sformatf("r%0d_addr", i), mem_addr, vt[i].addr);
            chk($sformatf("r%0d_wdata", i), mem_wdata, vt[i].ewd);
            @(posedge clk);
            #1;
            chk_wb($sformatf("r%0d", i), vt[i].wbv, vt[i].rdm, vt[i].walu,
                   vt[i].wm2r, vt[i].wrw, vt[i].wrd);
        end
        chk("table_err", {15'd0, mem_err}, 16'h0);

        // Timeout: load with no ack for 15 WAIT cycles
        @(negedge clk);
        drive(H, 16'h0050, 16'h0, H, L, H, H, 3'd6, L, 16'h0);
        #1;
        chk("to_req0", {15'd0, mem_req}, 16'h1);
        chk("to_stall0", {15'd0, stall}, 16'h1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_req%0d", i), {15'd0, mem_req}, 16'h1);
            chk($sformatf("to_addr%0d", i), mem_addr, 16'h0050);
            if (i < 15)
                chk($sformatf("to_stall%0d", i), {15'd0, stall}, 16'h1);
            @(posedge clk);
            #1;
            if (i < 15) begin
                chk($sformatf("to_wbv%0d", i), {15'd0, wb_valid}, 16'h0);
                chk($sformatf("to_err%0d", i), {15'd0, mem_err}, 16'h0);
            end
        end
        chk_wb("to_retire", H, 16'h0, 16'h0050, H, L, 3'd6);
        chk("to_err", {15'd0, mem_err}, 16'h1);
        @(negedge clk);
        drive(L, 16'h0, 16'h0, L, L, L, L, 3'd0, L, 16'h0);
        #1;
        chk("to_req_drop", {15'd0, mem_req}, 16'h0);
        chk("to_stall_drop", {15'd0, stall}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("to_wbv_after", {15'd0, wb_valid}, 16'h0);
        chk("to_err_sticky", {15'd0, mem_err}, 16'h1);

        // Reset in the 2nd WAIT cycle
        @(negedge clk);
        drive(H, 16'h0060, 16'h0, H, L, H, H, 3'd7, L, 16'h0);
        @(negedge clk);
        #1;
        chk("rs_wait1_req", {15'd0, mem_req}, 16'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_wb("rs", L, 16'h0, 16'h0, L, L, 3'd0);
        chk("rs_err", {15'd0, mem_err}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(L, 16'h0, 16'h0, L, L, L, L, 3'd0, L, 16'h0);
        #1;
        chk("rs_req", {15'd0, mem_req}, 16'h0);
        chk("rs_stall", {15'd0, stall}, 16'h0);
        @(negedge clk);
        drive(L, 16'h0, 16'h0, L, L, L, L, 3'd0, H, 16'h1234);
        #1;
        chk("rs_late_ack_req", {15'd0, mem_req}, 16'h0);
        @(posedge clk);
        #1;
        chk("rs_late_ack_wbv", {15'd0, wb_valid}, 16'h0);
        chk("rs_late_ack_rdata", read_data_mem, 16'h0);
        @(negedge clk);
        drive(L, 16'h0, 16'h0, L, L, L, L, 3'd0, L, 16'h0);
        #1;
        chk("rs_idle_req", {15'd0, mem_req}, 16'h0);
        chk("rs_idle_err", {15'd0, mem_err}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
